// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared rv32i definitions. Holds the reset PC default, the
//               canonical NOP encoding, the opcodes shared with the main
//               decoder and the fetch-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_OPIMM  = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC logic for the fetch stage: the
//               sequential pc+4 adder, the redirect mux and the target
//               alignment check.
// Ports       : pc                - address of the current instruction
//               pc_src            - redirect requested by execute
//               pc_target         - redirect target
//               pc_plus4          - pc + 4, modulo 2^32
//               next_pc           - pc_src ? pc_target : pc_plus4
//               target_misaligned - redirect requested to a non-word address
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import rv32_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        target_misaligned
);

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0 with no carry out.
    assign pc_plus4          = pc + 32'd4;
    assign next_pc           = pc_src ? pc_target : pc_plus4;
    assign target_misaligned = pc_src && (pc_target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : rv32i instruction fetch stage. Holds the fetch address,
//               requests instruction memory over req/ack, registers the
//               returned word and presents it with its PC to decode over a
//               valid/ready handshake. On acceptance it follows the redirect
//               from execute or advances by 4; a misaligned redirect target
//               parks the stage in TRAP until reset.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               imem_req/addr       - fetch request and word address
//               imem_ack/rdata      - memory response
//               instr, pc, pc_plus4 - instruction to decode and its address
//               instr_valid/ready   - decode handshake
//               pc_src, pc_target   - redirect, sampled on acceptance only
//               misalign            - sticky misaligned-target flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_target_misaligned;
    logic        w_accept;

    // The redirect inputs only matter on an accepted instruction; outside
    // that cycle the mux output is simply not consumed.
    assign w_accept = (r_state == ST_VALID) && instr_ready;

    pc_next u_pc_next (
        .pc                (r_pc),
        .pc_src            (pc_src),
        .pc_target         (pc_target),
        .pc_plus4          (pc_plus4),
        .next_pc           (w_next_pc),
        .target_misaligned (w_target_misaligned)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_FETCH;
            ST_FETCH: if (imem_ack) w_state_next = ST_VALID;
            ST_VALID: begin
                if (w_accept) begin
                    w_state_next = w_target_misaligned ? ST_TRAP : ST_FETCH;
                end
            end
            ST_TRAP:  w_state_next = ST_TRAP;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        misalign    = 1'b0;
        case (r_state)
            ST_FETCH: imem_req    = 1'b1;
            ST_VALID: instr_valid = 1'b1;
            ST_TRAP:  misalign    = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address, instruction and PC registers. The address only moves on
    // acceptance, so it is constant for the whole FETCH wait; instr/pc only
    // move on an ack in FETCH, so they hold while decode stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_IDLE: r_addr <= RESET_PC;
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_addr;
                    end
                end
                ST_VALID: begin
                    if (w_accept && !w_target_misaligned) begin
                        r_addr <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_addr;
    assign instr     = r_instr;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory model acks
//               requests after a programmable latency and pushes the
//               {address, word} it returned onto a scoreboard queue; each
//               test pops the queue when decode accepts an instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import rv32_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    wire         imem_ack;
    wire  [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        misalign;

    logic        auto_ack;
    logic [31:0] auto_rdata;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic        mem_en;
    int          mem_lat;
    int          wait_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    assign imem_ack   = auto_ack | man_ack;
    assign imem_rdata = man_ack ? man_rdata : auto_rdata;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .misalign    (misalign)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[26:2] ^ 25'h1A5_A5A5, OP_OPIMM};
    endfunction

    // Memory model: decides on the falling edge so the DUT sees a stable ack.
    initial begin
        auto_ack   = 1'b0;
        auto_rdata = 32'h0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (!reset && mem_en && imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    auto_ack   = 1'b1;
                    auto_rdata = word_of(imem_addr);
                    exp_q.push_back('{imem_addr, auto_rdata});
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first IDLE cycle after reset release.
    task automatic apply_reset();
        reset       = 1'b1;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        man_ack     = 1'b0;
        man_rdata   = 32'h0;
        mem_en      = 1'b0;
        mem_lat     = 0;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        if (ok) e = exp_q.pop_front();
        else    e = '{32'hx, 32'hx};
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h40;
        man_ack = 1'b0; man_rdata = 32'h0; mem_en = 1'b0; mem_lat = 0;
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
        total++; if (instr !== NOP_INSTR) begin bad++; $display("FAIL rst_instr got=%h exp=%h", instr, NOP_INSTR); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", pc); end
        total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4 got=%h exp=00000004", pc_plus4); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
    endtask

    // Zero-wait memory with decode always ready: 0,4,8,... every 2nd cycle.
    task automatic test_zero_wait();
        exp_t e; bit ok;
        logic [31:0] exp_addr;
        apply_reset();
        mem_en = 1'b1; instr_ready = 1'b1;
        exp_addr = RESET_PC_DEFAULT;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            total++;
            if (instr_valid !== (cyc >= 3 && cyc % 2 == 1)) begin
                bad++; $display("FAIL zw_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, (cyc >= 3 && cyc % 2 == 1));
            end
            total++;
            if (imem_req !== (cyc >= 2 && cyc % 2 == 0)) begin
                bad++; $display("FAIL zw_req cyc=%0d got=%b exp=%b", cyc, imem_req, (cyc >= 2 && cyc % 2 == 0));
            end
            if (imem_req) begin
                total++;
                if (imem_addr !== exp_addr) begin bad++; $display("FAIL zw_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_addr); end
            end
            if (instr_valid) begin
                pop_exp(e, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL zw_sb_empty cyc=%0d got=empty exp=entry", cyc); end
                else begin
                    total++; if (instr !== e.data) begin bad++; $display("FAIL zw_instr got=%h exp=%h", instr, e.data); end
                    total++; if (pc !== exp_addr) begin bad++; $display("FAIL zw_pc got=%h exp=%h", pc, exp_addr); end
                    total++; if (pc_plus4 !== exp_addr + 32'd4) begin bad++; $display("FAIL zw_pc_plus4 got=%h exp=%h", pc_plus4, exp_addr + 32'd4); end
                end
                exp_addr = exp_addr + 32'd4;
            end
            tick();
        end
    endtask

    // Three wait cycles before each ack: request must stay put meanwhile.
    task automatic test_slow_mem();
        exp_t e; bit ok; int req_cycles;
        apply_reset();
        mem_en = 1'b1; mem_lat = 3;
        tick();
        for (int k = 0; k < 2; k++) begin
            req_cycles = 0;
            while (imem_req && req_cycles < 20) begin
                total++;
                if (imem_addr !== 32'(k * 4)) begin bad++; $display("FAIL slow_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(k * 4)); end
                req_cycles++;
                tick();
            end
            total++; if (req_cycles !== 4) begin bad++; $display("FAIL slow_req_len k=%0d got=%0d exp=4", k, req_cycles); end
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL slow_valid k=%0d got=%b exp=1", k, instr_valid); end
            pop_exp(e, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL slow_sb_empty got=empty exp=entry"); end
            else begin
                total++; if (instr !== word_of(32'(k * 4))) begin bad++; $display("FAIL slow_instr got=%h exp=%h", instr, word_of(32'(k * 4))); end
                total++; if (pc !== e.addr) begin bad++; $display("FAIL slow_pc got=%h exp=%h", pc, e.addr); end
            end
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end
    endtask

    // Decode stalls 4 cycles: instr/pc frozen, no request, then pc+4 fetch.
    task automatic test_stall();
        exp_t e; bit ok;
        apply_reset();
        mem_en = 1'b1;
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=none exp=instr_valid"); end
        tick();
        pop_exp(e, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_sb_empty got=empty exp=entry"); end
        for (int i = 0; i < 4; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, instr_valid); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req i=%0d got=%b exp=0", i, imem_req); end
            total++; if (instr !== e.data) begin bad++; $display("FAIL stall_instr i=%0d got=%h exp=%h", i, instr, e.data); end
            total++; if (pc !== e.addr) begin bad++; $display("FAIL stall_pc i=%0d got=%h exp=%h", i, pc, e.addr); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_next_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== e.addr + 32'd4) begin bad++; $display("FAIL stall_next_addr got=%h exp=%h", imem_addr, e.addr + 32'd4); end
    endtask

    // Redirect honoured only on acceptance; ignored in IDLE/FETCH.
    task automatic test_redirect();
        exp_t e; bit ok;
        apply_reset();
        mem_en = 1'b1; pc_src = 1'b1; pc_target = 32'h200;
        tick();
        total++; if (imem_addr !== RESET_PC_DEFAULT) begin bad++; $display("FAIL redir_ignored_addr got=%h exp=%h", imem_addr, RESET_PC_DEFAULT); end
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL redir_timeout1 got=none exp=instr_valid"); end
        pop_exp(e, ok);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL redir_pc0 got=%h exp=00000000", pc); end
        pc_target = 32'h100; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; pc_target = 32'h300;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=00000100", imem_addr); end
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL redir_timeout2 got=none exp=instr_valid"); end
        pop_exp(e, ok);
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h exp=00000100", pc); end
        total++; if (ok && instr !== e.data) begin bad++; $display("FAIL redir_instr got=%h exp=%h", instr, e.data); end
        pc_src = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL redir_seq_addr got=%h exp=00000104", imem_addr); end
    endtask

    // Jump to the last word: pc+4 wraps to zero.
    task automatic test_wrap();
        exp_t e; bit ok;
        apply_reset();
        mem_en = 1'b1;
        wait_valid(10, ok);
        pop_exp(e, ok);
        pc_src = 1'b1; pc_target = 32'hFFFF_FFFC; instr_ready = 1'b1;
        tick();
        pc_src = 1'b0; instr_ready = 1'b0;
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=none exp=instr_valid"); end
        pop_exp(e, ok);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc); end
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus4 got=%h exp=00000000", pc_plus4); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
    endtask

    // Misaligned redirect traps until reset.
    task automatic test_misalign();
        exp_t e; bit ok;
        apply_reset();
        mem_en = 1'b1;
        wait_valid(10, ok);
        pop_exp(e, ok);
        pc_src = 1'b1; pc_target = 32'h102; instr_ready = 1'b1;
        tick();
        pc_src = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (misalign !== 1'b1) begin bad++; $display("FAIL trap_misalign i=%0d got=%b exp=1", i, misalign); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL trap_req i=%0d got=%b exp=0", i, imem_req); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL trap_valid i=%0d got=%b exp=0", i, instr_valid); end
            tick();
        end
        apply_reset();
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b exp=0", misalign); end
        mem_en = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL trap_refetch_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== RESET_PC_DEFAULT) begin bad++; $display("FAIL trap_refetch_addr got=%h exp=%h", imem_addr, RESET_PC_DEFAULT); end
    endtask

    // Reset while FETCH waits, with an ack in the reset cycle.
    task automatic test_reset_mid_fetch();
        exp_t e; bit ok;
        apply_reset();
        mem_en = 1'b1;
        wait_valid(10, ok);
        pop_exp(e, ok);
        mem_en = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rmf_waiting got=%b exp=1", imem_req); end
        reset = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        man_ack = 1'b0;
        total++; if (instr !== NOP_INSTR) begin bad++; $display("FAIL rmf_instr got=%h exp=%h", instr, NOP_INSTR); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmf_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmf_req got=%b exp=0", imem_req); end
        total++; if (pc !== RESET_PC_DEFAULT) begin bad++; $display("FAIL rmf_pc got=%h exp=%h", pc, RESET_PC_DEFAULT); end
        reset = 1'b0;
        tick();
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmf_post_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== NOP_INSTR) begin bad++; $display("FAIL rmf_post_instr got=%h exp=%h", instr, NOP_INSTR); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
